// File: rtl/pwm_sample_scheduler.sv
// Period-aligned duty loader for the PWM generator; tick at T -> src_ready at T+1 -> value at T+2.
// Waits at most TIMEOUT cycles for src_valid, else flags underrun; DUTY_CLAMP_EN saturates samples to [DUTY_MIN, DUTY_MAX].
module pwm_sample_scheduler #(
    parameter logic [31:0] CLKFREQ  = 32'd10000000,
    parameter logic [31:0] FREQ     = 32'd200000,
    parameter int          NUM_SRC  = 4,
    parameter int          TIMEOUT  = 8,
    parameter logic [9:0]  DUTY_MIN = 10'd0,
    parameter logic [9:0]  DUTY_MAX = 10'd1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    rr_mode,
    input  logic [1:0]              ch_sel,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [10*NUM_SRC-1:0]   src_sample,
    output logic [NUM_SRC-1:0]      src_ready,
    input  logic                    underrun_clr,
    output logic [9:0]              value,
    output logic                    period_tick,
    output logic [1:0]              cur_ch,
    output logic                    underrun
);

    localparam int              PERIOD    = int'(CLKFREQ / FREQ);
    localparam int              CW        = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int              WW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [3:0]      CH_OK     = 4'((1 << NUM_SRC) - 1);
    localparam logic [1:0]      PTR_LAST  = 2'(NUM_SRC - 1);

    if (NUM_SRC < 1 || NUM_SRC > 4) begin : g_bad_num_src
        $error("pwm_sample_scheduler: NUM_SRC must be in 1..4");
    end
    if (TIMEOUT < 1 || TIMEOUT > PERIOD - 4) begin : g_bad_timeout
        $error("pwm_sample_scheduler: TIMEOUT must be in 1..PERIOD-4");
    end

`ifdef DUTY_CLAMP_EN
    if (DUTY_MIN > DUTY_MAX) begin : g_bad_clamp
        $error("pwm_sample_scheduler: DUTY_MIN exceeds DUTY_MAX");
    end

    function automatic logic [9:0] load_val(input logic [9:0] s);
        if (s <= DUTY_MIN)      return DUTY_MIN;
        else if (s >= DUTY_MAX) return DUTY_MAX;
        else                    return s;
    endfunction
`else
    logic unused_clamp_bounds;
    assign unused_clamp_bounds = ^{DUTY_MIN, DUTY_MAX};

    function automatic logic [9:0] load_val(input logic [9:0] s);
        return s;
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tick_q, tick_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      cur_q, cur_d;
    logic [9:0]      value_q, value_d;
    logic            und_q, und_d;

    logic [9:0]      sel_sample;
    logic [1:0]      ch_pick;
    logic            xfer;
    logic            und_set;

    always_comb begin
        src_ready  = '0;
        sel_sample = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_q == 2'(i)) begin
                src_ready[i] = (state_q == REQ);
                sel_sample   = src_sample[10*i +: 10];
            end
        end
        xfer = |(src_valid & src_ready);
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        value_d = value_q;
        und_set = 1'b0;
        ch_pick = rr_mode ? ((ptr_q == PTR_LAST) ? 2'd0 : ptr_q + 2'd1) : ch_sel;
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        tick_d  = (cnt_d == CNT_LAST);

        if (!en) begin
            // Disabling aborts any request silently and restarts the period from zero.
            cnt_d   = '0;
            tick_d  = 1'b0;
            state_d = IDLE;
            wait_d  = '0;
            value_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick_q) begin
                        cur_d  = ch_pick;
                        wait_d = '0;
                        if (rr_mode) ptr_d = ch_pick;
                        if (!rr_mode && !CH_OK[ch_sel]) begin
                            und_set = 1'b1;
                            state_d = HOLD;
                        end else begin
                            state_d = REQ;
                        end
                    end
                end
                REQ: begin
                    if (xfer) begin
                        value_d = load_val(sel_sample);
                        state_d = HOLD;
                    end else if (wait_q == WAIT_LAST) begin
                        und_set = 1'b1;
                        state_d = HOLD;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                HOLD:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // A new fault in the same cycle as a clear must stay visible.
        und_d = und_set ? 1'b1 : (underrun_clr ? 1'b0 : und_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            wait_q  <= '0;
            ptr_q   <= PTR_LAST;
            cur_q   <= 2'd0;
            value_q <= '0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            wait_q  <= wait_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            value_q <= value_d;
            und_q   <= und_d;
        end
    end

    assign value       = value_q;
    assign period_tick = tick_q;
    assign cur_ch      = cur_q;
    assign underrun    = und_q;

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Directed bench for pwm_sample_scheduler: vector table of one-period requests plus reset and enable-drop sequences.
module tb_pwm_sample_scheduler;

    localparam int PERIOD  = 50;
    localparam int TIMEOUT = 8;

`ifdef DUTY_CLAMP_EN
    localparam logic [9:0] EXP_HI = 10'd1000;
    localparam logic [9:0] EXP_LO = 10'd16;
`else
    localparam logic [9:0] EXP_HI = 10'd1023;
    localparam logic [9:0] EXP_LO = 10'd3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rr_mode;
    logic [1:0]  ch_sel;
    logic [3:0]  src_valid;
    logic [39:0] src_sample;
    logic [3:0]  src_ready;
    logic        underrun_clr;
    logic [9:0]  value;
    logic        period_tick;
    logic [1:0]  cur_ch;
    logic        underrun;

    int n_cmp = 0;
    int n_err = 0;

    pwm_sample_scheduler #(
        .CLKFREQ  (32'd10000000),
        .FREQ     (32'd200000),
        .NUM_SRC  (4),
        .TIMEOUT  (TIMEOUT),
        .DUTY_MIN (10'd16),
        .DUTY_MAX (10'd1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .rr_mode      (rr_mode),
        .ch_sel       (ch_sel),
        .src_valid    (src_valid),
        .src_sample   (src_sample),
        .src_ready    (src_ready),
        .underrun_clr (underrun_clr),
        .value        (value),
        .period_tick  (period_tick),
        .cur_ch       (cur_ch),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rr;
        logic [1:0]  sel;
        logic        clr;
        logic [3:0]  vld;
        logic [39:0] smp;
        logic [9:0]  e_val;
        logic [1:0]  e_ch;
        logic        e_und;
        logic [3:0]  e_rdy;
        int          e_cnt;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_tick(input string nm);
        int k = 0;
        while (period_tick !== 1'b1 && k < 2*PERIOD) begin
            @(negedge clk);
            k++;
        end
        check(nm, int'(period_tick), 1);
    endtask

    // Counts cycles from the current one (numbered 1) until period_tick is seen.
    task automatic count_to_tick(output int k);
        k = 1;
        while (period_tick !== 1'b1 && k < 3*PERIOD) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [3:0] rdy_or;
        int         rdy_cnt;
        logic [9:0] val_t2;
        logic [1:0] ch_t1;
        repeat (4) @(negedge clk);
        rr_mode      = v.rr;
        ch_sel       = v.sel;
        src_valid    = v.vld;
        src_sample   = v.smp;
        underrun_clr = v.clr;
        @(negedge clk);
        underrun_clr = 1'b0;
        wait_tick($sformatf("v%0d tick", idx));
        rdy_or  = '0;
        rdy_cnt = 0;
        val_t2  = '0;
        ch_t1   = '0;
        for (int c = 1; c <= TIMEOUT + 3; c++) begin
            @(negedge clk);
            if (c == 1) ch_t1 = cur_ch;
            if (c == 2) val_t2 = value;
            rdy_or = rdy_or | src_ready;
            if (src_ready != 4'b0) rdy_cnt++;
        end
        check($sformatf("v%0d cur_ch@T+1", idx), int'(ch_t1), int'(v.e_ch));
        check($sformatf("v%0d value@T+2", idx), int'(val_t2), int'(v.e_val));
        check($sformatf("v%0d value", idx), int'(value), int'(v.e_val));
        check($sformatf("v%0d cur_ch", idx), int'(cur_ch), int'(v.e_ch));
        check($sformatf("v%0d underrun", idx), int'(underrun), int'(v.e_und));
        check($sformatf("v%0d ready bits", idx), int'(rdy_or), int'(v.e_rdy));
        check($sformatf("v%0d ready cycles", idx), rdy_cnt, v.e_cnt);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        logic [39:0] s_fix, s_rr, s_hi, s_lo, s_ch1;
        s_fix = {10'd0, 10'd512, 10'd0, 10'd0};
        s_ch1 = {10'd0, 10'd0, 10'd777, 10'd0};
        s_rr  = {10'd400, 10'd300, 10'd200, 10'd100};
        s_hi  = {10'd1023, 10'd5, 10'd5, 10'd5};
        s_lo  = {10'd900, 10'd900, 10'd900, 10'd3};

        //        rr    sel   clr   vld      smp    val      ch    und   rdy      cnt
        vt[0] = '{1'b0, 2'd2, 1'b0, 4'b0100, s_fix, 10'd512, 2'd2, 1'b0, 4'b0100, 1};
        vt[1] = '{1'b0, 2'd1, 1'b0, 4'b1101, s_ch1, 10'd512, 2'd1, 1'b1, 4'b0010, TIMEOUT};
        vt[2] = '{1'b1, 2'd3, 1'b1, 4'b1111, s_rr,  10'd100, 2'd0, 1'b0, 4'b0001, 1};
        vt[3] = '{1'b1, 2'd3, 1'b0, 4'b1111, s_rr,  10'd200, 2'd1, 1'b0, 4'b0010, 1};
        vt[4] = '{1'b1, 2'd3, 1'b0, 4'b1111, s_rr,  10'd300, 2'd2, 1'b0, 4'b0100, 1};
        vt[5] = '{1'b1, 2'd3, 1'b0, 4'b1111, s_rr,  10'd400, 2'd3, 1'b0, 4'b1000, 1};
        vt[6] = '{1'b1, 2'd3, 1'b0, 4'b1111, s_rr,  10'd100, 2'd0, 1'b0, 4'b0001, 1};
        vt[7] = '{1'b0, 2'd3, 1'b0, 4'b1111, s_hi,  EXP_HI,  2'd3, 1'b0, 4'b1000, 1};
        vt[8] = '{1'b0, 2'd0, 1'b0, 4'b1111, s_lo,  EXP_LO,  2'd0, 1'b0, 4'b0001, 1};

        rst          = 1'b1;
        en           = 1'b0;
        rr_mode      = 1'b0;
        ch_sel       = 2'd0;
        src_valid    = 4'b0;
        src_sample   = '0;
        underrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("reset value", int'(value), 0);
        check("reset src_ready", int'(src_ready), 0);
        check("reset underrun", int'(underrun), 0);
        check("reset cur_ch", int'(cur_ch), 0);
        check("reset period_tick", int'(period_tick), 0);

        // Reset in the middle of a request to source 1.
        rst    = 1'b0;
        en     = 1'b1;
        ch_sel = 2'd1;
        wait_tick("pre-reset tick");
        @(negedge clk);
        check("mid-request ready", int'(src_ready), 4'b0010);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        ch_sel     = 2'd0;
        src_valid  = 4'b0001;
        src_sample = '0;
        check("rst value", int'(value), 0);
        check("rst src_ready", int'(src_ready), 0);
        check("rst underrun", int'(underrun), 0);
        check("rst cur_ch", int'(cur_ch), 0);
        check("rst period_tick", int'(period_tick), 0);
        count_to_tick(k);
        check("first tick cycle after reset", k, PERIOD);

        for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

        // Drop enable while a request is outstanding.
        repeat (4) @(negedge clk);
        rr_mode   = 1'b0;
        ch_sel    = 2'd1;
        src_valid = 4'b0000;
        wait_tick("en-drop tick");
        @(negedge clk);
        check("en-drop ready before", int'(src_ready), 4'b0010);
        en = 1'b0;
        @(negedge clk);
        check("en-drop src_ready", int'(src_ready), 0);
        check("en-drop value", int'(value), 0);
        check("en-drop underrun", int'(underrun), 0);
        check("en-drop period_tick", int'(period_tick), 0);
        repeat (TIMEOUT + 2) @(negedge clk);
        check("en-low no underrun", int'(underrun), 0);
        check("en-low src_ready", int'(src_ready), 0);
        en = 1'b1;
        count_to_tick(k);
        check("first tick cycle after re-enable", k, PERIOD);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_sample_scheduler.md
Name: pwm_sample_scheduler

Overview:
Sequences duty-cycle updates into the PWM generator from up to four waveform sources (sine/square/triangle/etc.). Once per PWM period it requests one 10-bit sample from the selected source over a valid/ready handshake. It registers the sample as the generator's `value` input, so duty changes are period-aligned. It arbitrates sources in fixed-select or round-robin (time-multiplexed) mode and flags underruns when a source fails to deliver.

Parameters:
- CLKFREQ, 32'd10000000, system clock frequency in Hz.
- FREQ, 32'd200000, PWM frequency in Hz; PERIOD = CLKFREQ/FREQ (default 50 cycles).
- NUM_SRC, 4, number of sources; legal range 1..4.
- TIMEOUT, 8, maximum cycles spent waiting for `src_valid`; must satisfy TIMEOUT <= PERIOD-4 (elaboration error otherwise).
- DUTY_MIN, 10'd0, lower clamp bound (used only with DUTY_CLAMP_EN).
- DUTY_MAX, 10'd1023, upper clamp bound (used only with DUTY_CLAMP_EN).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scheduler enable.
- rr_mode  in  1  0 = fixed select via `ch_sel`; 1 = round-robin.
- ch_sel  in  2  source index in fixed mode, sampled at tick.
- src_valid  in  NUM_SRC  per-source sample valid.
- src_sample  in  10*NUM_SRC  per-source sample; source i occupies bits [10*i+9:10*i].
- src_ready  out  NUM_SRC  per-source ready; one-hot or zero.
- underrun_clr  in  1  clears `underrun`.
- value  out  10  duty value to the PWM generator.
- period_tick  out  1  one-cycle pulse on the last cycle of each period.
- cur_ch  out  2  index of the source last requested.
- underrun  out  1  sticky fault flag.

Behaviour:
- Reset (rst=1 at posedge): cnt=0, state=IDLE, value=0, src_ready=0, period_tick=0, cur_ch=0, underrun=0, RR pointer=NUM_SRC-1. rst overrides everything else.
- Period counter cnt: 0..PERIOD-1, increments each cycle while en=1, wraps to 0. `period_tick` is registered and is 1 in exactly the cycle where cnt==PERIOD-1.
- FSM states: IDLE, REQ, HOLD.
  - IDLE: on a cycle where cnt==PERIOD-1 and en=1, select a channel and go to REQ.
    - Fixed mode: ch = ch_sel.
    - RR mode: ch = (ptr+1) mod NUM_SRC and ptr <= ch; the pointer advances whether or not the transfer succeeds.
    - `cur_ch` <= ch.
  - REQ: src_ready[cur_ch]=1; all other ready bits are 0.
    - Transfer occurs when src_valid[cur_ch] && src_ready[cur_ch]. On that edge, value <= the sample (clamped if the feature is enabled), state moves to HOLD, and ready drops the next cycle.
    - Wait counter starts at 0 on entry. If TIMEOUT cycles elapse with no transfer: underrun <= 1, value is held, state moves to HOLD.
    - Worst case, ready is high for exactly TIMEOUT cycles.
  - HOLD: ready is 0. Return to IDLE on the next cycle.
- Latency: tick at cycle T -> ready high at T+1. With valid already high, the transfer happens at T+1 and `value` updates at T+2.
- Invalid channel: in fixed mode with ch_sel >= NUM_SRC, no ready is asserted. underrun <= 1 and state moves directly to HOLD; value is held.
- Extra valids from unselected sources are ignored. Only one transfer is allowed per period.
- underrun: sticky. If underrun_clr and a new underrun event occur in the same cycle, the set wins.
- en=0 in any state: on the next edge, state=IDLE, src_ready=0, cnt=0, value=0. An in-flight request is aborted without flagging underrun. After re-enable, the first tick is PERIOD cycles later.
- Width rules: `value` is always exactly 10 bits; samples are not scaled.

Optional Feature:
- Macro: DUTY_CLAMP_EN.
- Defined: the loaded sample is saturated to [DUTY_MIN, DUTY_MAX] before it is registered into `value`. If DUTY_MIN > DUTY_MAX, elaboration fails.
- Undefined: the sample passes unchanged; DUTY_MIN and DUTY_MAX are unused.

Test Plan:
1. Assert rst for 2 cycles mid-request -> value=0, src_ready=0, underrun=0, cur_ch=0, cnt=0; the first period_tick arrives 50 cycles after rst deasserts.
2. rr_mode=0, ch_sel=2, src_valid[2]=1 with sample=512 -> src_ready=4'b0100 for one cycle after the tick; value=512 two cycles after the tick; no other ready bit ever asserts.
3. ch_sel=1, src_valid[1]=0 -> src_ready[1] high for exactly 8 cycles, then underrun=1 and value stays 512. Pulsing underrun_clr then clears the flag.
4. rr_mode=1, sources hold samples 100/200/300/400 with valid=1 -> value steps through 100, 200, 300, 400, 100 on successive periods, and cur_ch steps 0, 1, 2, 3, 0.
5. Drop en while in REQ -> next edge src_ready=0, value=0, cnt=0, underrun unchanged; on re-enable, the next tick arrives at 50 cycles.
6. With DUTY_CLAMP_EN, DUTY_MIN=16, DUTY_MAX=1000: sample 1023 -> value=1000; sample 3 -> value=16. Without the macro, samples 1023 and 3 pass unchanged.
